// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core sequencer.
// Bus width, op codes and the sequencer state encoding.
package tensor_core_pkg;

  localparam int BUS_WIDTH = 8;

  localparam logic [1:0] OP_MATMUL = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_RELU   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    CAPTURE,
    DRAIN
  } state_t;

endpackage

// File: rtl/tensor_core_result_serializer.sv
// Nine-entry result buffer streamed out row-major
// over a valid/ready byte interface.
module tensor_core_result_serializer
  import tensor_core_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic signed [BUS_WIDTH-1:0] din [9],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BUS_WIDTH-1:0] out_data,
  output logic                        last
);

  logic signed [BUS_WIDTH-1:0] buffer [9];
  logic [3:0] k;
  logic       active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      k      <= 4'd0;
      for (int i = 0; i < 9; i++) begin
        buffer[i] <= '0;
      end
    end else if (load) begin
      buffer <= din;
      k      <= 4'd0;
      active <= 1'b1;
    end else if (active && out_ready) begin
      if (k == 4'd8) begin
        active <= 1'b0;
        k      <= 4'd0;
      end else begin
        k <= k + 4'd1;
      end
    end
  end

  assign out_valid = active && !rst;
  assign out_data  = buffer[k];
  assign last      = (k == 4'd8);

endmodule

// File: rtl/tensor_core_sequencer.sv
// Byte-stream front end for a 3x3 tensor core: loads operands,
// pulses start, waits, captures results and serializes them.
module tensor_core_sequencer
  import tensor_core_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic                        tensor_core_clock,
  input  logic                        tensor_core_reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BUS_WIDTH-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BUS_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic signed [BUS_WIDTH-1:0] tensor_core_input1 [3][3],
  output logic signed [BUS_WIDTH-1:0] tensor_core_input2 [3][3],
  output logic                        tensor_core_register_file_write_enable,
  output logic                        should_start_tensor_core,
  output logic [1:0]                  operation_select,
  input  logic signed [BUS_WIDTH-1:0] tensor_core_output [3][3]
);

  localparam int WW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  state_t state, next_state;

  logic [4:0]    idx;
  logic [WW-1:0] wcnt;
  logic [1:0]    op;
  logic [3:0]    elem;
  logic          second;
  logic          hdr_fire;
  logic          load_fire;
  logic          wait_done;
  logic          ser_last;
  logic          ser_load;

  logic signed [BUS_WIDTH-1:0] flat [9];

  assign hdr_fire  = (state == IDLE) && in_valid && !tensor_core_reset;
  assign load_fire = (state == LOAD) && in_valid && !tensor_core_reset;
  assign wait_done = (wcnt == WW'(COMPUTE_CYCLES - 1));
  assign second    = (idx >= 5'd9);
  assign elem      = second ? 4'(idx - 5'd9) : idx[3:0];
  assign ser_load  = (state == CAPTURE);

  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (hdr_fire) next_state = LOAD;
      LOAD:    if (load_fire && idx == 5'd17) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (wait_done) next_state = CAPTURE;
      CAPTURE: next_state = DRAIN;
      DRAIN:   if (out_valid && out_ready && ser_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    should_start_tensor_core = 1'b0;
    tensor_core_register_file_write_enable = tensor_core_reset;
    if (!tensor_core_reset) begin
      in_ready = (state == IDLE) || (state == LOAD);
      busy     = (state != IDLE);
      should_start_tensor_core = (state == START);
      tensor_core_register_file_write_enable = load_fire;
    end
  end

  // Operand, op and counter registers
  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      idx  <= '0;
      wcnt <= '0;
      op   <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tensor_core_input1[r][c] <= '0;
          tensor_core_input2[r][c] <= '0;
        end
      end
    end else begin
      if (hdr_fire) begin
        op  <= in_data[1:0];
        idx <= '0;
      end
      if (load_fire) begin
        idx <= idx + 5'd1;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            if (elem == 4'(r * 3 + c)) begin
              if (second) begin
                tensor_core_input2[r][c] <= in_data;
              end else begin
                tensor_core_input1[r][c] <= in_data;
              end
            end
          end
        end
      end
      if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
      end else begin
        wcnt <= '0;
      end
    end
  end

  assign operation_select = op;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        flat[r * 3 + c] = tensor_core_output[r][c];
      end
    end
  end

  tensor_core_result_serializer u_ser (
    .clk       (tensor_core_clock),
    .rst       (tensor_core_reset),
    .load      (ser_load),
    .din       (flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Directed bench for tensor_core_sequencer with a
// behavioural 3x3 tensor core model on the operand ports.
module tb_tensor_core_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic       busy;
  logic       we;
  logic       start;
  logic [1:0] opsel;
  logic signed [7:0] out_data;
  logic signed [7:0] a_mat [3][3];
  logic signed [7:0] b_mat [3][3];
  logic signed [7:0] tc_out [3][3];

  logic [7:0] va [9];
  logic [7:0] vb [9];
  logic [7:0] ve [9];
  logic [7:0] hold_byte;
  logic [1:0] cur_op;
  int stall_k;
  logic hold;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tensor_core_sequencer #(.COMPUTE_CYCLES(10)) dut (
    .tensor_core_clock                      (clk),
    .tensor_core_reset                      (rst),
    .in_valid                               (in_valid),
    .in_ready                               (in_ready),
    .in_data                                (in_data),
    .out_valid                              (out_valid),
    .out_ready                              (out_ready),
    .out_data                               (out_data),
    .busy                                   (busy),
    .tensor_core_input1                     (a_mat),
    .tensor_core_input2                     (b_mat),
    .tensor_core_register_file_write_enable (we),
    .should_start_tensor_core               (start),
    .operation_select                       (opsel),
    .tensor_core_output                     (tc_out)
  );

  // Tensor core model: result registered on the start pulse
  always @(posedge clk) begin : tc_model
    int s;
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          tc_out[r][c] <= '0;
    end else if (start) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          s = 0;
          if (opsel == 2'b00) begin
            for (int k = 0; k < 3; k++) s += a_mat[r][k] * b_mat[k][c];
          end else if (opsel == 2'b01) begin
            s = a_mat[r][c] + b_mat[r][c];
          end else begin
            s = (a_mat[r][c] < 0) ? 0 : a_mat[r][c];
          end
          tc_out[r][c] <= 8'(s);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic we_exp);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    chk("in_ready_load", {7'd0, in_ready}, 8'd1);
    chk("write_enable", {7'd0, we}, {7'd0, we_exp});
    @(negedge clk);
  endtask

  task automatic load_body();
    for (int i = 0; i < 9; i++) send(va[i], 1'b1);
    for (int i = 0; i < 9; i++) send(vb[i], 1'b1);
    in_valid = hold;
    in_data  = hold ? hold_byte : 8'd0;
  endtask

  task automatic drain_check();
    int lat;
    chk("start_pulse", {7'd0, start}, 8'd1);
    chk("opsel_start", {6'd0, opsel}, {6'd0, cur_op});
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("start_once", {7'd0, start}, 8'd0);
      if (hold) chk("in_ready_wait", {7'd0, in_ready}, 8'd0);
    end
    chk("latency", 8'(lat), 8'd12);
    for (int k = 0; k < 9; k++) begin
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (3) begin
          chk("stall_data", out_data, ve[k]);
          chk("stall_valid", {7'd0, out_valid}, 8'd1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk("out_data", out_data, ve[k]);
      chk("out_valid", {7'd0, out_valid}, 8'd1);
      if (hold) chk("in_ready_drain", {7'd0, in_ready}, 8'd0);
      @(negedge clk);
    end
    chk("busy_after", {7'd0, busy}, 8'd0);
    chk("valid_after", {7'd0, out_valid}, 8'd0);
  endtask

  initial begin
    hold = 1'b0;
    hold_byte = 8'd0;
    stall_k = 99;

    // Reset state
    @(negedge clk);
    chk("rst_we", {7'd0, we}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_start", {7'd0, start}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {7'd0, in_ready}, 8'd1);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);

    // Matmul: identity x 1..9, stall on byte 4
    va = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    vb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    ve = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    cur_op = 2'b00;
    stall_k = 4;
    send(8'h00, 1'b0);
    load_body();
    drain_check();
    chk("keep_a00", a_mat[0][0], 8'd1);
    chk("keep_b22", b_mat[2][2], 8'd9);

    // Add: 3 + -5
    va = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    vb = '{8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB};
    ve = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
    cur_op = 2'b01;
    stall_k = 99;
    send(8'h01, 1'b0);
    load_body();
    drain_check();

    // Relu, with the next header held on in_valid throughout
    va = '{8'hFF, 8'd2, 8'hFD, 8'd4, 8'hFB, 8'd6, 8'hF9, 8'd8, 8'hF7};
    vb = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    ve = '{8'd0, 8'd2, 8'd0, 8'd4, 8'd0, 8'd6, 8'd0, 8'd8, 8'd0};
    cur_op = 2'b10;
    hold = 1'b1;
    hold_byte = 8'h01;
    send(8'h02, 1'b0);
    load_body();
    drain_check();
    chk("idle_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    chk("held_hdr_busy", {7'd0, busy}, 8'd1);
    chk("held_hdr_op", {6'd0, opsel}, 8'd1);
    hold = 1'b0;

    // Add: 1..9 + 10 via the held header
    va = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    vb = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
    ve = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
    cur_op = 2'b01;
    load_body();
    drain_check();

    // Reset mid-LOAD after 7 operand bytes
    send(8'h00, 1'b0);
    send(8'd1, 1'b1);
    for (int i = 0; i < 6; i++) send(8'd0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", {7'd0, we}, 8'd1);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_ready", {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_post_ready", {7'd0, in_ready}, 8'd1);
    chk("mid_post_busy", {7'd0, busy}, 8'd0);
    chk("mid_post_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_post_a00", a_mat[0][0], 8'd0);
    @(negedge clk);

    va = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    vb = '{8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB};
    ve = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
    cur_op = 2'b01;
    send(8'h01, 1'b0);
    load_body();
    drain_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tensor_core_sequencer.md
TENSOR_CORE_SEQUENCER -- requirements
Module: tensor_core_sequencer

Interface
REQ-001 SHALL have parameter COMPUTE_CYCLES, default 10, meaning the number of cycles waited after the start pulse before results are captured.
REQ-002 SHALL have port tensor_core_clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port tensor_core_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: command byte valid.
REQ-005 SHALL have port in_ready, output, 1 bit: command byte accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data, input, 8 bits: command byte stream.
REQ-007 SHALL have port out_valid, output, 1 bit: result byte valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts a result byte.
REQ-009 SHALL have port out_data, output, signed 8 bits: result byte.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have ports tensor_core_input1 and tensor_core_input2, output, signed 8 bits x [3][3] each: operand matrices.
REQ-012 SHALL have port tensor_core_register_file_write_enable, output, 1 bit: operand write strobe.
REQ-013 SHALL have port should_start_tensor_core, output, 1 bit: start pulse.
REQ-014 SHALL have port operation_select, output, 2 bits: operation code.
REQ-015 SHALL have port tensor_core_output, input, signed 8 bits x [3][3]: tensor core results.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, START, WAIT, CAPTURE, DRAIN.
REQ-017 IDLE SHALL hold in_ready=1; on an accepted byte it SHALL latch op=in_data[1:0] and go to LOAD.
REQ-018 LOAD SHALL hold in_ready=1 and accept 18 bytes, row-major: bytes 0-8 go to input1[r][c] and bytes 9-17 go to input2[r][c], with r=idx/3 and c=idx%3.
REQ-019 Each accepted LOAD byte SHALL assert tensor_core_register_file_write_enable for exactly that cycle.
REQ-020 After byte 17 is accepted, the FSM SHALL go to START.
REQ-021 START SHALL last 1 cycle, with should_start_tensor_core=1 and operation_select=op; the FSM then goes to WAIT.
REQ-022 operation_select SHALL hold op from START until the next header is accepted.
REQ-023 Op codes SHALL be 00=matmul, 01=add, and 10 or 11=relu; codes pass through unmodified; the B bytes are still consumed for relu.
REQ-024 WAIT SHALL count exactly COMPUTE_CYCLES cycles, then go to CAPTURE.
REQ-025 CAPTURE SHALL, in 1 cycle, copy all 9 elements of tensor_core_output into a result buffer, then go to DRAIN.
REQ-026 Results SHALL be stored and emitted at 8 bits without widening or saturation.
REQ-027 DRAIN SHALL present buffer[k] row-major, k=0..8, on out_data with out_valid=1.
REQ-028 k SHALL advance only when out_valid && out_ready.
REQ-029 While out_ready=0, out_data SHALL stay stable.
REQ-030 After byte 8 is accepted, the FSM SHALL return to IDLE the next cycle; the first new header is accepted no earlier than that cycle.
REQ-031 in_ready SHALL be 0 in START, WAIT, CAPTURE and DRAIN; in_valid in those states SHALL be ignored and SHALL NOT be consumed.
REQ-032 out_valid SHALL be 0 outside DRAIN.
REQ-033 Latency, from acceptance of byte 17 to the first out_valid, SHALL be COMPUTE_CYCLES+2 cycles.
REQ-034 Operand registers SHALL retain their values after LOAD until overwritten by the next LOAD.

Reset
REQ-035 tensor_core_reset=1 at a rising edge SHALL force IDLE from any state, including mid-LOAD and mid-DRAIN.
REQ-036 Under reset, all byte and wait counters SHALL be cleared to 0.
REQ-037 Under reset, operands, results and op SHALL be cleared to 0.
REQ-038 Under reset, out_valid, should_start_tensor_core and busy SHALL be 0.
REQ-039 Under reset, tensor_core_register_file_write_enable SHALL be 1, which parks the tensor core.
REQ-040 in_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-041 Any partial transaction SHALL be discarded on reset; no result bytes from it SHALL be emitted.

Structure
REQ-042 Package tensor_core_pkg SHALL hold BUS_WIDTH=8, the op codes OP_MATMUL, OP_ADD and OP_RELU, and the FSM state enum.
REQ-043 The DRAIN buffer and index SHALL live in one sub-module, tensor_core_result_serializer, which takes a 9-element load strobe plus a valid/ready output.
REQ-044 The rest of the block SHALL be flat.

Verification
REQ-045 Matmul: header 0x00, A=identity, B=1..9 -> out 1,2,...,9; first out_valid 12 cycles after byte 17.
REQ-046 Add: header 0x01, A all 3, B all -5 -> nine bytes 0xFE; busy falls the cycle after the last byte.
REQ-047 Relu: header 0x02, A=-1,2,-3,4,-5,6,-7,8,-9, B all 0x7F -> 0,2,0,4,0,6,0,8,0.
REQ-048 Backpressure: out_ready=0 for 3 cycles while byte 4 is presented -> out_data held at that value, no byte skipped or duplicated, 9 bytes total.
REQ-049 Reset mid-LOAD after 7 bytes -> next cycle in_ready=1, busy=0, out_valid=0; a following complete add transaction gives the correct results.
REQ-050 in_valid held high during WAIT and DRAIN -> no byte consumed; the next header is accepted only in IDLE.
